// File: rtl/base64_seq_ctrl.sv
// Serialises ASCII characters from two round-robin requesters, MSB first, into a
// Base64 converter; pads each message with zero bits up to a whole 6-bit group.
module base64_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [6:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       cvt_bit,
  output logic       cvt_en,
  output logic       sextet_tick,
  output logic [1:0] grant,
  output logic       busy,
  output logic       msg_done,
  output logic [2:0] pad_bits
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_WAIT  = 3'd2,
    S_PAD   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e     state_q;
  logic [6:0] sh_q;
  logic       last_q;
  logic [2:0] bit_q;
  logic [2:0] grp_q;
  logic [2:0] pad_q;
  logic [1:0] grant_q;
  logic       rr_q;
  logic       cvt_en_q;
  logic       msg_done_q;
  logic [2:0] pad_bits_q;

  logic       arb0, arb1;
  logic       accept_slot;
  logic [1:0] hs;
  logic       hs_any;
  logic [6:0] hs_data;
  logic       hs_last;
  logic [2:0] grp_d;
  logic       grp_wrap;

  // Between messages the pointer only breaks ties; a lone requester always wins.
  assign arb0 = req0_valid & (~rr_q | ~req1_valid);
  assign arb1 = req1_valid & ( rr_q | ~req0_valid);

  // Mid-message, only the owner may hand over the next character.
  assign accept_slot = (state_q == S_WAIT) |
                       ((state_q == S_SHIFT) & (bit_q == 3'd6) & ~last_q);

  assign req0_ready = rst_n & ((state_q == S_IDLE) ? arb0 : (accept_slot & grant_q[0]));
  assign req1_ready = rst_n & ((state_q == S_IDLE) ? arb1 : (accept_slot & grant_q[1]));

  assign hs      = {req1_valid & req1_ready, req0_valid & req0_ready};
  assign hs_any  = |hs;
  assign hs_data = hs[1] ? req1_data : req0_data;
  assign hs_last = hs[1] ? req1_last : req0_last;

  assign grp_wrap = (grp_q == 3'd5);
  assign grp_d    = grp_wrap ? 3'd0 : grp_q + 3'd1;

  assign cvt_en      = cvt_en_q;
  assign cvt_bit     = cvt_en_q & sh_q[6];
  assign sextet_tick = cvt_en_q & grp_wrap;
  assign grant       = grant_q;
  assign busy        = |grant_q;
  assign msg_done    = msg_done_q;
  assign pad_bits    = pad_bits_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sh_q       <= 7'd0;
      last_q     <= 1'b0;
      bit_q      <= 3'd0;
      grp_q      <= 3'd0;
      pad_q      <= 3'd0;
      grant_q    <= 2'b00;
      rr_q       <= 1'b0;
      cvt_en_q   <= 1'b0;
      msg_done_q <= 1'b0;
      pad_bits_q <= 3'd0;
    end else begin
      msg_done_q <= 1'b0;
      pad_bits_q <= 3'd0;
      if (cvt_en_q) begin
        grp_q <= grp_d;
      end

      case (state_q)
        S_IDLE: begin
          if (hs_any) begin
            sh_q     <= hs_data;
            last_q   <= hs_last;
            bit_q    <= 3'd0;
            grant_q  <= hs;
            cvt_en_q <= 1'b1;
            state_q  <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          sh_q  <= {sh_q[5:0], 1'b0};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd6) begin
            bit_q <= 3'd0;
            if (last_q) begin
              // A message already ending on a group boundary needs no padding.
              if (grp_wrap) begin
                cvt_en_q   <= 1'b0;
                msg_done_q <= 1'b1;
                pad_bits_q <= 3'd0;
                state_q    <= S_DONE;
              end else begin
                state_q <= S_PAD;
              end
            end else if (hs_any) begin
              sh_q   <= hs_data;
              last_q <= hs_last;
            end else begin
              cvt_en_q <= 1'b0;
              state_q  <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (hs_any) begin
            sh_q     <= hs_data;
            last_q   <= hs_last;
            bit_q    <= 3'd0;
            cvt_en_q <= 1'b1;
            state_q  <= S_SHIFT;
          end
        end

        S_PAD: begin
          pad_q <= pad_q + 3'd1;
          if (grp_wrap) begin
            cvt_en_q   <= 1'b0;
            msg_done_q <= 1'b1;
            pad_bits_q <= pad_q + 3'd1;
            state_q    <= S_DONE;
          end
        end

        S_DONE: begin
          rr_q    <= grant_q[0];
          grant_q <= 2'b00;
          grp_q   <= 3'd0;
          pad_q   <= 3'd0;
          last_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          cvt_en_q <= 1'b0;
          grant_q  <= 2'b00;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
